// File: rtl/cdb_broadcast_arbiter_pkg.sv
// Shared types and constants for the CDB broadcast arbiter.
// Holds the functional-unit index map, the broadcast tag packet, the per-FU
// readiness packet returned to the reservation station, and a one-hot to
// index helper.
package cdb_broadcast_arbiter_pkg;

  localparam int NUM_FU   = 8;   // functional units
  localparam int CDB_W    = 3;   // broadcast slots per cycle
  localparam int PRW      = 6;   // physical register tag width
  localparam int XLEN     = 32;  // result data width
  localparam int FU_IDX_W = 3;   // log2(NUM_FU)

  // Fixed functional-unit index map.
  typedef enum logic [FU_IDX_W-1:0] {
    FU_ALU_1       = 3'd0,
    FU_ALU_2       = 3'd1,
    FU_ALU_3       = 3'd2,
    FU_MULT_1      = 3'd3,
    FU_MULT_2      = 3'd4,
    FU_STORELOAD_1 = 3'd5,
    FU_STORELOAD_2 = 3'd6,
    FU_BRANCH      = 3'd7
  } FU_SELECT;

  // Broadcast tags; t2 carries the first grant, t0 the third.
  typedef struct packed {
    logic [PRW-1:0] t2;
    logic [PRW-1:0] t1;
    logic [PRW-1:0] t0;
  } CDB_T_PACKET;

  // One issue-permission bit per FU; bit position equals the FU index.
  typedef struct packed {
    logic branch;
    logic storeload_2;
    logic storeload_1;
    logic mult_2;
    logic mult_1;
    logic alu_3;
    logic alu_2;
    logic alu_1;
  } FU_STATE_PACKET;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic logic [FU_IDX_W-1:0] onehot_to_idx(input logic [NUM_FU-1:0] oh);
    logic [FU_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (oh[i]) idx = idx | FU_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cdb_broadcast_arbiter_rr_pick.sv
// Rotating one-hot picker over NUM_FU requesters.
// Ports:
//   req  - request vector, one bit per FU
//   ptr  - index searched first; search wraps upward from here
//   gnt  - one-hot grant (all zero when no request)
//   any  - at least one request was granted
module cdb_broadcast_arbiter_rr_pick
  import cdb_broadcast_arbiter_pkg::*;
(
  input  logic [NUM_FU-1:0]   req,
  input  logic [FU_IDX_W-1:0] ptr,
  output logic [NUM_FU-1:0]   gnt,
  output logic                any
);

  logic [FU_IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned, which would infer a latch.
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      // NUM_FU is a power of two, so the FU_IDX_W-bit add wraps modulo NUM_FU.
      idx = ptr + FU_IDX_W'(off);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// Complete-stage CDB broadcast arbiter.
// Captures finished results from the 8 functional units into per-FU hold
// registers and broadcasts up to 3 of them per cycle with rotating fairness.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   squash        - mispredict flush; drops every held result at the edge
//   fu_done       - FU i presents a finished result this cycle
//   fu_dest_pr    - destination physical tag per FU
//   fu_value      - result value per FU
//   fu_accept     - FU i's result is captured at this edge if presented
//   fu_ready      - fu_accept packed as FU_STATE_PACKET for the RS
//   cdb_t         - broadcast tags t2 (first grant), t1, t0
//   cdb_valid     - slot k carries a real broadcast (bit 2 = t2)
//   cdb_value     - value per slot (index 2 = t2)
module cdb_broadcast_arbiter
  import cdb_broadcast_arbiter_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_FU-1:0]              fu_done,
  input  logic [NUM_FU-1:0][PRW-1:0]     fu_dest_pr,
  input  logic [NUM_FU-1:0][XLEN-1:0]    fu_value,
  output logic [NUM_FU-1:0]              fu_accept,
  output FU_STATE_PACKET                 fu_ready,
  output CDB_T_PACKET                    cdb_t,
  output logic [CDB_W-1:0]               cdb_valid,
  output logic [CDB_W-1:0][XLEN-1:0]     cdb_value
);

  logic [NUM_FU-1:0]           hold_valid_q, hold_valid_d;
  logic [NUM_FU-1:0][PRW-1:0]  hold_dest_q,  hold_dest_d;
  logic [NUM_FU-1:0][XLEN-1:0] hold_value_q, hold_value_d;
  logic [FU_IDX_W-1:0]         rr_ptr_q,     rr_ptr_d;

  // Three chained picks; each stage sees only requests not yet granted.
  logic [NUM_FU-1:0] req_0, req_1, req_2;
  logic [NUM_FU-1:0] gnt_0, gnt_1, gnt_2;
  logic              any_0, any_1, any_2;
  logic [NUM_FU-1:0] grant_all;
  logic [NUM_FU-1:0] last_gnt;
  logic [NUM_FU-1:0] capture;

  assign req_0 = hold_valid_q;
  assign req_1 = req_0 & ~gnt_0;
  assign req_2 = req_1 & ~gnt_1;

  cdb_broadcast_arbiter_rr_pick u_pick_0 (.req(req_0), .ptr(rr_ptr_q), .gnt(gnt_0), .any(any_0));
  cdb_broadcast_arbiter_rr_pick u_pick_1 (.req(req_1), .ptr(rr_ptr_q), .gnt(gnt_1), .any(any_1));
  cdb_broadcast_arbiter_rr_pick u_pick_2 (.req(req_2), .ptr(rr_ptr_q), .gnt(gnt_2), .any(any_2));

  assign grant_all = gnt_0 | gnt_1 | gnt_2;

  // A granted slot drains this edge, so its FU may hand over a new result.
  assign fu_accept = ~hold_valid_q | grant_all;
  assign fu_ready  = FU_STATE_PACKET'(fu_accept);
  assign capture   = fu_done & fu_accept;

  // Slot muxing: grants are one-hot, so the assignments never collide.
  // Unused slots stay at tag 0 (the hardwired zero register) and value 0.
  always_comb begin
    cdb_t     = '0;
    cdb_value = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt_0[i]) begin
        cdb_t.t2     = hold_dest_q[i];
        cdb_value[2] = hold_value_q[i];
      end
      if (gnt_1[i]) begin
        cdb_t.t1     = hold_dest_q[i];
        cdb_value[1] = hold_value_q[i];
      end
      if (gnt_2[i]) begin
        cdb_t.t0     = hold_dest_q[i];
        cdb_value[0] = hold_value_q[i];
      end
    end
  end

  assign cdb_valid = {any_0, any_1, any_2};

  // Pointer advances past the last FU granted this cycle; a squash freezes it.
  always_comb begin
    last_gnt = any_2 ? gnt_2 : (any_1 ? gnt_1 : gnt_0);
    rr_ptr_d = rr_ptr_q;
    if (any_0 && !squash) begin
      rr_ptr_d = onehot_to_idx(last_gnt) + FU_IDX_W'(1);
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_dest_d  = hold_dest_q;
    hold_value_d = hold_value_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (capture[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_dest_d[i]  = fu_dest_pr[i];
        hold_value_d[i] = fu_value[i];
      end else if (grant_all[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
    // Flush overrides captures made in the same edge.
    if (squash) hold_valid_d = '0;
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // its pre-edge inputs regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // NOTE: the payload registers carry no reset; they are only observed when
  // the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clock) begin
    hold_dest_q  <= hold_dest_d;
    hold_value_q <= hold_value_d;
  end

  // An FU must not present a result while its hold register is still full.
  a_no_done_when_busy: assert property (@(posedge clock) disable iff (reset)
    (fu_done & ~fu_accept) == '0);

endmodule
